// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the SRAM responder: bus encodings, response codes,
// FSM states and the data-phase record captured at address-phase accept.
package ahb_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SizeByte = 3'd0,
        SizeHalf = 3'd1,
        SizeWord = 3'd2
    } hsize_e;

    typedef enum logic [2:0] {
        BurstSingle = 3'd0,
        BurstIncr   = 3'd1,
        BurstWrap4  = 3'd2,
        BurstIncr4  = 3'd3,
        BurstWrap8  = 3'd4,
        BurstIncr8  = 3'd5,
        BurstWrap16 = 3'd6,
        BurstIncr16 = 3'd7
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StOkay,
        StErr1,
        StErr2
    } state_e;

    typedef struct packed {
        logic [15:0] idx;
        logic        write;
        logic [3:0]  strb;
        logic        err;
    } dphase_t;

endpackage

// File: rtl/ahb_lane_decode.sv
// Little-endian byte-lane decode of HADDR[1:0]/HSIZE with alignment and size checks.
module ahb_lane_decode
    import ahb_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [2:0] size,
    output logic [3:0] strb,
    output logic       misalign,
    output logic       bad_size
);

    always_comb begin
        strb     = 4'b0000;
        misalign = 1'b0;
        bad_size = 1'b0;
        case (size)
            SizeByte: strb = 4'b0001 << addr_lo;
            SizeHalf: begin
                strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                misalign = addr_lo[0];
            end
            SizeWord: begin
                strb     = 4'b1111;
                misalign = |addr_lo;
            end
            default:  bad_size = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite responder backed by a 32-bit word SRAM, with programmable wait states,
// two-cycle ERROR responses and read-after-write forwarding.
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dphase_t     rec_q, rec_d, rec_new;
    logic [31:0] hrdata_d;
    logic [31:0] rd_word;
    logic [31:0] mem [MEM_DEPTH];

    logic [3:0]  strb;
    logic        misalign, bad_size, out_of_range;
    logic        can_accept, accept, idle_sel;

    ahb_lane_decode u_lane_decode (
        .addr_lo  (HADDR[1:0]),
        .size     (HSIZE),
        .strb     (strb),
        .misalign (misalign),
        .bad_size (bad_size)
    );

    assign out_of_range  = {2'b00, HADDR[31:2]} >= MEM_DEPTH;
    assign rec_new.idx   = HADDR[17:2];
    assign rec_new.write = HWRITE;
    assign rec_new.strb  = strb;
    assign rec_new.err   = out_of_range | misalign | bad_size;

    // A new address phase is only sampled while no stalled data phase is in flight.
    assign can_accept = (state_q == StIdle) || (state_q == StOkay) || (state_q == StErr2);
    assign accept     = can_accept && HSEL && HREADY && HTRANS[1];
    assign idle_sel   = can_accept && HSEL && HREADY && !HTRANS[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rec_d     = rec_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            StWait: begin
                HREADYOUT = 1'b0;
                if (cnt_q == 4'd0) state_d = StOkay;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = StErr2;
            end
            StErr2: begin
                HRESP   = HRESP_ERROR;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (accept) begin
            rec_d = rec_new;
            if (rec_new.err) begin
                state_d = StErr1;
            end else if (WAIT_STATES > 0) begin
                state_d = StWait;
                cnt_d   = WAIT_INIT;
            end else begin
                state_d = StOkay;
            end
        end
    end

    // Read value for the beat entering OKAY, merged with a write retiring on the same edge.
    always_comb begin
        rd_word = mem[rec_d.idx[IDX_W-1:0]];
        if (state_q == StOkay && rec_q.write && rec_q.idx == rec_d.idx) begin
            for (int i = 0; i < 4; i++) begin
                if (rec_q.strb[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
        hrdata_d = HRDATA;
        if (state_d == StOkay)      hrdata_d = rec_d.write ? 32'h0 : rd_word;
        else if (state_d == StErr1) hrdata_d = 32'h0;
        else if (idle_sel)          hrdata_d = 32'h0;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rec_q   <= '0;
            HRDATA  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rec_q   <= rec_d;
            HRDATA  <= hrdata_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESET && state_q == StOkay && rec_q.write) begin
            for (int i = 0; i < 4; i++) begin
                if (rec_q.strb[i]) mem[rec_q.idx[IDX_W-1:0]][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{HBURST, HTRANS[0], rec_q.err, rec_q.idx};

endmodule
